// File: rtl/clock_phase_gen_pkg.sv
`default_nettype none
// ============================================================================
// Module      : clock_phase_gen_pkg
// Description : Shared types and helpers for the multi-phase clock generator:
//               FSM state encoding, minimum divide ratio and the clamp
//               functions applied when a new configuration is captured.
// Revision    : 1.0 - initial release
// ============================================================================
package clock_phase_gen_pkg;

    // Smallest divide ratio that still produces a high and a low half-period.
    localparam int unsigned MIN_DIV = 2;

    // Generator state: IDLE holds everything at zero, SYNC runs the first
    // period of a configuration, RUN is the steady locked state.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SYNC = 2'd1,
        RUN  = 2'd2
    } state_e;

    // Raise a requested divide ratio to at least MIN_DIV.
    function automatic int unsigned clamp_div(input int unsigned value);
        return (value < MIN_DIV) ? MIN_DIV : value;
    endfunction

    // Keep a phase offset inside the period of an already clamped ratio.
    function automatic int unsigned clamp_phase(input int unsigned value,
                                                input int unsigned limit);
        return (value >= limit) ? (limit - 1) : value;
    endfunction

endpackage
`default_nettype wire

// File: rtl/clock_phase_slice.sv
`default_nettype none
// ============================================================================
// Module      : clock_phase_slice
// Description : One phase output of clock_phase_gen. Computes
//               ((cnt - phase) mod div) < div/2 without a divider, registers
//               the result as ph_clk and optionally emits a rise strobe.
// Options     : CLOCK_PHASE_GEN_PULSE_EN builds the rise-strobe register;
//               without it ph_pulse is tied low.
// Revision    : 1.0 - initial release
// ============================================================================
module clock_phase_slice
    import clock_phase_gen_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic [CNT_W-1:0] cnt,
    input  logic [CNT_W-1:0] div,
    input  logic [CNT_W-1:0] phase,
    output logic             ph_clk,
    output logic             ph_pulse
);

    logic [CNT_W:0] diff_w;
    logic [CNT_W:0] dist_w;
    logic           ph_clk_d;
    logic           ph_clk_q;

    // Modular distance from the phase origin; both operands are below div,
    // so one conditional add of div brings a negative difference back in range.
    always_comb begin
        diff_w   = {1'b0, cnt} - {1'b0, phase};
        dist_w   = diff_w;
        if (diff_w[CNT_W]) begin
            dist_w = diff_w + {1'b0, div};
        end
        ph_clk_d = run && (dist_w < {1'b0, (div >> 1)});
    end

    // Phase output register; zero whenever the generator is not running.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ph_clk_q <= 1'b0;
        end else begin
            ph_clk_q <= ph_clk_d;
        end
    end

    assign ph_clk = ph_clk_q;

`ifdef CLOCK_PHASE_GEN_PULSE_EN
    logic ph_pulse_d;
    logic ph_pulse_q;

    // A rise is the next registered value high while the current one is low.
    always_comb begin
        ph_pulse_d = ph_clk_d && !ph_clk_q;
    end

    // Strobe register, updated on the same edge that raises ph_clk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ph_pulse_q <= 1'b0;
        end else begin
            ph_pulse_q <= ph_pulse_d;
        end
    end

    assign ph_pulse = ph_pulse_q;
`else
    assign ph_pulse = 1'b0;
`endif

endmodule
`default_nettype wire

// File: rtl/clock_phase_gen.sv
`default_nettype none
// ============================================================================
// Module      : clock_phase_gen
// Description : Programmable multi-phase clock generator. Divides clk by a
//               runtime ratio and emits NUM_PH registered, phase-shifted
//               divided clocks. New settings arrive over a valid/ready
//               handshake into a shadow register and are applied only at a
//               period boundary (or immediately while idle).
// Options     : CLOCK_PHASE_GEN_PULSE_EN enables the per-phase rise strobes
//               on ph_pulse; otherwise ph_pulse is constant zero.
// Revision    : 1.0 - initial release
// ============================================================================
module clock_phase_gen
    import clock_phase_gen_pkg::*;
#(
    parameter int NUM_PH      = 4,
    parameter int CNT_W       = 8,
    parameter int DEFAULT_DIV = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    cfg_valid,
    output logic                    cfg_ready,
    input  logic [CNT_W-1:0]        div_cfg,
    input  logic [NUM_PH*CNT_W-1:0] phase_cfg,
    output logic [NUM_PH-1:0]       ph_clk,
    output logic [NUM_PH-1:0]       ph_pulse,
    output logic                    locked
);

    localparam logic [CNT_W-1:0] c_cnt_one     = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_default_div = CNT_W'(DEFAULT_DIV);
    localparam int               c_reset_step  = DEFAULT_DIV / NUM_PH;

    state_e                         state_q;
    state_e                         state_d;
    logic [CNT_W-1:0]               cnt_q;
    logic [CNT_W-1:0]               cnt_d;
    logic [CNT_W-1:0]               div_q;
    logic [CNT_W-1:0]               div_d;
    logic [NUM_PH-1:0][CNT_W-1:0]   phase_q;
    logic [NUM_PH-1:0][CNT_W-1:0]   phase_d;
    logic                           sh_valid_q;
    logic                           sh_valid_d;
    logic [CNT_W-1:0]               sh_div_q;
    logic [CNT_W-1:0]               sh_div_d;
    logic [NUM_PH-1:0][CNT_W-1:0]   sh_phase_q;
    logic [NUM_PH-1:0][CNT_W-1:0]   sh_phase_d;
    logic                           locked_q;
    logic                           locked_d;

    logic                           run_w;
    logic                           wrap_w;
    logic                           capture_w;
    logic                           apply_w;
    logic [CNT_W-1:0]               div_clamped_w;

    // Control strobes. A wrap is judged regardless of en so that an apply
    // landing on the same cycle en falls still completes.
    always_comb begin
        run_w     = (state_q != IDLE) && en;
        wrap_w    = (state_q != IDLE) && (cnt_q == div_q - c_cnt_one);
        capture_w = cfg_valid && !sh_valid_q;
        apply_w   = sh_valid_q && ((state_q == IDLE) || wrap_w);
    end

    // Shadow register: clamp at capture, empty again once applied. Capture
    // needs an empty shadow, so it never coincides with an apply and a
    // capture on a wrap cycle waits for the following wrap.
    always_comb begin
        sh_valid_d    = sh_valid_q;
        sh_div_d      = sh_div_q;
        sh_phase_d    = sh_phase_q;
        div_clamped_w = CNT_W'(clamp_div(32'(div_cfg)));
        if (capture_w) begin
            sh_valid_d = 1'b1;
            sh_div_d   = div_clamped_w;
            for (int i = 0; i < NUM_PH; i++) begin
                sh_phase_d[i] = CNT_W'(clamp_phase(32'(phase_cfg[i*CNT_W +: CNT_W]),
                                                   32'(div_clamped_w)));
            end
        end else if (apply_w) begin
            sh_valid_d = 1'b0;
        end
    end

    // Active configuration follows the shadow only on an apply.
    always_comb begin
        div_d   = div_q;
        phase_d = phase_q;
        if (apply_w) begin
            div_d   = sh_div_q;
            phase_d = sh_phase_q;
        end
    end

    // Divide counter: held at zero unless running, wraps after div-1.
    always_comb begin
        cnt_d = '0;
        if (run_w && !wrap_w) begin
            cnt_d = cnt_q + c_cnt_one;
        end
    end

    // Next state and lock flag. Any apply at a wrap restarts the SYNC period
    // so locked only reports a full period run under the active settings.
    always_comb begin
        state_d = state_q;
        if (!en) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: state_d = SYNC;
                SYNC: begin
                    if (wrap_w) begin
                        state_d = apply_w ? SYNC : RUN;
                    end
                end
                RUN: begin
                    if (apply_w) begin
                        state_d = SYNC;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        locked_d = (state_d == RUN);
    end

    // State, counter and configuration registers; reset discards any shadow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            div_q      <= c_default_div;
            sh_valid_q <= 1'b0;
            sh_div_q   <= c_default_div;
            sh_phase_q <= '0;
            locked_q   <= 1'b0;
            for (int i = 0; i < NUM_PH; i++) begin
                phase_q[i] <= CNT_W'(i * c_reset_step);
            end
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            div_q      <= div_d;
            phase_q    <= phase_d;
            sh_valid_q <= sh_valid_d;
            sh_div_q   <= sh_div_d;
            sh_phase_q <= sh_phase_d;
            locked_q   <= locked_d;
        end
    end

    assign cfg_ready = !sh_valid_q;
    assign locked    = locked_q;

    for (genvar g = 0; g < NUM_PH; g++) begin : g_slice
        clock_phase_slice #(
            .CNT_W (CNT_W)
        ) u_slice (
            .clk      (clk),
            .rst_n    (rst_n),
            .run      (run_w),
            .cnt      (cnt_q),
            .div      (div_q),
            .phase    (phase_q[g]),
            .ph_clk   (ph_clk[g]),
            .ph_pulse (ph_pulse[g])
        );
    end

endmodule
`default_nettype wire

// File: tb/tb_clock_phase_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_clock_phase_gen
// Description : Directed self-checking bench for clock_phase_gen with the
//               default parameters (NUM_PH=4, CNT_W=8, DEFAULT_DIV=8).
//               Expected per-cycle values are hand-computed tables.
// Options     : honours CLOCK_PHASE_GEN_PULSE_EN for the ph_pulse model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_clock_phase_gen;

    localparam int NUM_PH = 4;
    localparam int CNT_W  = 8;

`ifdef CLOCK_PHASE_GEN_PULSE_EN
    localparam logic [3:0] PULSE_MASK = 4'hF;
`else
    localparam logic [3:0] PULSE_MASK = 4'h0;
`endif

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic                    en;
    logic                    cfg_valid;
    logic                    cfg_ready;
    logic [CNT_W-1:0]        div_cfg;
    logic [NUM_PH*CNT_W-1:0] phase_cfg;
    logic [NUM_PH-1:0]       ph_clk;
    logic [NUM_PH-1:0]       ph_pulse;
    logic                    locked;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    clock_phase_gen u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .div_cfg   (div_cfg),
        .phase_cfg (phase_cfg),
        .ph_clk    (ph_clk),
        .ph_pulse  (ph_pulse),
        .locked    (locked)
    );

    // Expected strobe: a rise of the expected ph_clk, when the strobe is built.
    function automatic logic [3:0] pulse_model(input logic [3:0] cur, input logic [3:0] prev);
        return (cur & ~prev) & PULSE_MASK;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        en        = 1'b0;
        cfg_valid = 1'b0;
        div_cfg   = '0;
        phase_cfg = '0;
        tick();
        tick();
        rst_n     = 1'b1;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        en        = 1'b0;
        cfg_valid = 1'b0;
        div_cfg   = '0;
        phase_cfg = '0;
        tick();
        tick();
        n_checks++; if (ph_clk !== 4'h0)   begin n_errors++; $display("FAIL reset ph_clk got=%h exp=0", ph_clk); end
        n_checks++; if (ph_pulse !== 4'h0) begin n_errors++; $display("FAIL reset ph_pulse got=%h exp=0", ph_pulse); end
        n_checks++; if (locked !== 1'b0)   begin n_errors++; $display("FAIL reset locked got=%b exp=0", locked); end
        n_checks++; if (cfg_ready !== 1'b1) begin n_errors++; $display("FAIL reset cfg_ready got=%b exp=1", cfg_ready); end
        rst_n = 1'b1;
        repeat (3) tick();
        n_checks++; if (ph_clk !== 4'h0)   begin n_errors++; $display("FAIL idle ph_clk got=%h exp=0", ph_clk); end
        n_checks++; if (locked !== 1'b0)   begin n_errors++; $display("FAIL idle locked got=%b exp=0", locked); end
        n_checks++; if (cfg_ready !== 1'b1) begin n_errors++; $display("FAIL idle cfg_ready got=%b exp=1", cfg_ready); end
    endtask

    task automatic test_defaults();
        logic [3:0] exp_ph [16];
        logic       exp_lk [16];
        logic [3:0] prev;
        exp_ph = '{4'h0, 4'h9, 4'h9, 4'h3, 4'h3, 4'h6, 4'h6, 4'hC,
                   4'hC, 4'h9, 4'h9, 4'h3, 4'h3, 4'h6, 4'h6, 4'hC};
        exp_lk = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                   1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        prev = 4'h0;
        do_reset();
        en = 1'b1;
        for (int k = 0; k < 16; k++) begin
            tick();
            n_checks++; if (ph_clk !== exp_ph[k]) begin n_errors++; $display("FAIL defaults ph_clk cyc=%0d got=%h exp=%h", k+1, ph_clk, exp_ph[k]); end
            n_checks++; if (locked !== exp_lk[k]) begin n_errors++; $display("FAIL defaults locked cyc=%0d got=%b exp=%b", k+1, locked, exp_lk[k]); end
            n_checks++; if (ph_pulse !== pulse_model(exp_ph[k], prev)) begin n_errors++; $display("FAIL defaults ph_pulse cyc=%0d got=%h exp=%h", k+1, ph_pulse, pulse_model(exp_ph[k], prev)); end
            n_checks++; if (cfg_ready !== 1'b1) begin n_errors++; $display("FAIL defaults cfg_ready cyc=%0d got=%b exp=1", k+1, cfg_ready); end
            prev = exp_ph[k];
        end
    endtask

    task automatic test_reconfig();
        logic [3:0] exp_ph [18];
        logic       exp_lk [18];
        logic       exp_rd [18];
        logic [3:0] prev;
        exp_ph = '{4'h3, 4'h6, 4'h6, 4'hC, 4'hC, 4'h1, 4'h3, 4'h7, 4'hE,
                   4'hC, 4'h8, 4'h1, 4'h3, 4'h7, 4'hE, 4'hC, 4'h8, 4'h1};
        exp_lk = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                   1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        exp_rd = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
                   1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        prev = 4'h3;
        do_reset();
        en = 1'b1;
        repeat (12) tick();
        n_checks++; if (cfg_ready !== 1'b1) begin n_errors++; $display("FAIL reconfig pre cfg_ready got=%b exp=1", cfg_ready); end
        cfg_valid = 1'b1;
        div_cfg   = 8'd6;
        phase_cfg = {8'd3, 8'd2, 8'd1, 8'd0};
        for (int k = 0; k < 18; k++) begin
            tick();
            cfg_valid = 1'b0;
            n_checks++; if (ph_clk !== exp_ph[k]) begin n_errors++; $display("FAIL reconfig ph_clk cyc=%0d got=%h exp=%h", k+13, ph_clk, exp_ph[k]); end
            n_checks++; if (locked !== exp_lk[k]) begin n_errors++; $display("FAIL reconfig locked cyc=%0d got=%b exp=%b", k+13, locked, exp_lk[k]); end
            n_checks++; if (cfg_ready !== exp_rd[k]) begin n_errors++; $display("FAIL reconfig cfg_ready cyc=%0d got=%b exp=%b", k+13, cfg_ready, exp_rd[k]); end
            n_checks++; if (ph_pulse !== pulse_model(exp_ph[k], prev)) begin n_errors++; $display("FAIL reconfig ph_pulse cyc=%0d got=%h exp=%h", k+13, ph_pulse, pulse_model(exp_ph[k], prev)); end
            prev = exp_ph[k];
        end
    endtask

    task automatic test_clamp();
        logic [3:0] exp_ph [8];
        logic       exp_lk [8];
        logic [3:0] prev;
        exp_ph = '{4'h0, 4'h5, 4'hA, 4'h5, 4'hA, 4'h5, 4'hA, 4'h5};
        exp_lk = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        prev = 4'h0;
        do_reset();
        cfg_valid = 1'b1;
        div_cfg   = 8'd1;
        phase_cfg = {8'd1, 8'd0, 8'd9, 8'd0};
        tick();
        cfg_valid = 1'b0;
        n_checks++; if (cfg_ready !== 1'b0) begin n_errors++; $display("FAIL clamp capture cfg_ready got=%b exp=0", cfg_ready); end
        tick();
        n_checks++; if (cfg_ready !== 1'b1) begin n_errors++; $display("FAIL clamp idle-apply cfg_ready got=%b exp=1", cfg_ready); end
        n_checks++; if (ph_clk !== 4'h0)    begin n_errors++; $display("FAIL clamp idle ph_clk got=%h exp=0", ph_clk); end
        en = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            n_checks++; if (ph_clk !== exp_ph[k]) begin n_errors++; $display("FAIL clamp ph_clk cyc=%0d got=%h exp=%h", k+3, ph_clk, exp_ph[k]); end
            n_checks++; if (locked !== exp_lk[k]) begin n_errors++; $display("FAIL clamp locked cyc=%0d got=%b exp=%b", k+3, locked, exp_lk[k]); end
            n_checks++; if (ph_pulse !== pulse_model(exp_ph[k], prev)) begin n_errors++; $display("FAIL clamp ph_pulse cyc=%0d got=%h exp=%h", k+3, ph_pulse, pulse_model(exp_ph[k], prev)); end
            prev = exp_ph[k];
        end
    endtask

    task automatic test_odd_simultaneous();
        logic [3:0] exp_ph [17];
        logic       exp_lk [17];
        logic       exp_rd [17];
        logic [3:0] prev;
        exp_ph = '{4'h0, 4'h1, 4'h3, 4'h6, 4'hC, 4'h8, 4'h1, 4'h3, 4'h6,
                   4'hC, 4'h8, 4'h1, 4'h3, 4'h6, 4'hC, 4'h8, 4'h9};
        exp_lk = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1,
                   1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        exp_rd = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
                   1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        prev = 4'h0;
        do_reset();
        cfg_valid = 1'b1;
        div_cfg   = 8'd5;
        phase_cfg = {8'd3, 8'd2, 8'd1, 8'd0};
        tick();
        cfg_valid = 1'b0;
        tick();
        en = 1'b1;
        for (int k = 0; k < 17; k++) begin
            tick();
            cfg_valid = 1'b0;
            n_checks++; if (ph_clk !== exp_ph[k]) begin n_errors++; $display("FAIL odd ph_clk cyc=%0d got=%h exp=%h", k+3, ph_clk, exp_ph[k]); end
            n_checks++; if (locked !== exp_lk[k]) begin n_errors++; $display("FAIL odd locked cyc=%0d got=%b exp=%b", k+3, locked, exp_lk[k]); end
            n_checks++; if (cfg_ready !== exp_rd[k]) begin n_errors++; $display("FAIL odd cfg_ready cyc=%0d got=%b exp=%b", k+3, cfg_ready, exp_rd[k]); end
            n_checks++; if (ph_pulse !== pulse_model(exp_ph[k], prev)) begin n_errors++; $display("FAIL odd ph_pulse cyc=%0d got=%h exp=%h", k+3, ph_pulse, pulse_model(exp_ph[k], prev)); end
            prev = exp_ph[k];
            if (k == 9) begin
                // Counter sits at div-1: this capture coincides with the wrap.
                cfg_valid = 1'b1;
                div_cfg   = 8'd4;
                phase_cfg = {8'd3, 8'd2, 8'd1, 8'd0};
            end
        end
    endtask

    task automatic test_disable_reset();
        logic [3:0] exp_ph [10];
        logic       exp_lk [10];
        logic [3:0] prev;
        exp_ph = '{4'h0, 4'h9, 4'h9, 4'h3, 4'h3, 4'h6, 4'h6, 4'hC, 4'hC, 4'h9};
        exp_lk = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        do_reset();
        en = 1'b1;
        repeat (10) tick();
        n_checks++; if (ph_clk !== 4'h9) begin n_errors++; $display("FAIL disable running ph_clk got=%h exp=9", ph_clk); end
        n_checks++; if (locked !== 1'b1) begin n_errors++; $display("FAIL disable running locked got=%b exp=1", locked); end
        en = 1'b0;
        tick();
        n_checks++; if (ph_clk !== 4'h0)   begin n_errors++; $display("FAIL disable ph_clk got=%h exp=0", ph_clk); end
        n_checks++; if (locked !== 1'b0)   begin n_errors++; $display("FAIL disable locked got=%b exp=0", locked); end
        n_checks++; if (ph_pulse !== 4'h0) begin n_errors++; $display("FAIL disable ph_pulse got=%h exp=0", ph_pulse); end
        tick();
        n_checks++; if (ph_clk !== 4'h0)    begin n_errors++; $display("FAIL disable hold ph_clk got=%h exp=0", ph_clk); end
        n_checks++; if (cfg_ready !== 1'b1) begin n_errors++; $display("FAIL disable hold cfg_ready got=%b exp=1", cfg_ready); end
        en = 1'b1;
        tick();
        cfg_valid = 1'b1;
        div_cfg   = 8'd3;
        phase_cfg = '0;
        tick();
        cfg_valid = 1'b0;
        n_checks++; if (cfg_ready !== 1'b0) begin n_errors++; $display("FAIL pending cfg_ready got=%b exp=0", cfg_ready); end
        #1 rst_n = 1'b0;
        #1;
        n_checks++; if (cfg_ready !== 1'b1) begin n_errors++; $display("FAIL async-reset cfg_ready got=%b exp=1", cfg_ready); end
        n_checks++; if (ph_clk !== 4'h0)    begin n_errors++; $display("FAIL async-reset ph_clk got=%h exp=0", ph_clk); end
        n_checks++; if (locked !== 1'b0)    begin n_errors++; $display("FAIL async-reset locked got=%b exp=0", locked); end
        #1 rst_n = 1'b1;
        prev = 4'h0;
        for (int k = 0; k < 10; k++) begin
            tick();
            n_checks++; if (ph_clk !== exp_ph[k]) begin n_errors++; $display("FAIL post-reset ph_clk cyc=%0d got=%h exp=%h", k+1, ph_clk, exp_ph[k]); end
            n_checks++; if (locked !== exp_lk[k]) begin n_errors++; $display("FAIL post-reset locked cyc=%0d got=%b exp=%b", k+1, locked, exp_lk[k]); end
            n_checks++; if (cfg_ready !== 1'b1)   begin n_errors++; $display("FAIL post-reset cfg_ready cyc=%0d got=%b exp=1", k+1, cfg_ready); end
            n_checks++; if (ph_pulse !== pulse_model(exp_ph[k], prev)) begin n_errors++; $display("FAIL post-reset ph_pulse cyc=%0d got=%h exp=%h", k+1, ph_pulse, pulse_model(exp_ph[k], prev)); end
            prev = exp_ph[k];
        end
    endtask

    initial begin
        test_reset();
        test_defaults();
        test_reconfig();
        test_clamp();
        test_odd_simultaneous();
        test_disable_reset();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/clock_phase_gen.md
Name: clock_phase_gen

Overview:
- Programmable multi-phase clock generator. Divides `clk` by a runtime ratio and emits NUM_PH registered, phase-shifted divided clocks.
- Sits beside the clock-phasing logic and feeds downstream sampling and strobe logic that needs fixed phase relationships.
- Configuration is updated by a valid/ready handshake. New settings are applied only at a period boundary, so no output glitches.

Parameters:
- NUM_PH, 4, number of phase outputs.
- CNT_W, 8, width of the divide counter and of each phase offset.
- DEFAULT_DIV, 8, divide ratio after reset (must be >= 2).

Ports:
- clk  in  1  system clock; every register rises on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  run enable; 0 forces IDLE.
- cfg_valid  in  1  new configuration offered.
- cfg_ready  out  1  shadow register free to accept a configuration.
- div_cfg  in  CNT_W  requested divide ratio.
- phase_cfg  in  NUM_PH*CNT_W  offset of phase i, in clk cycles, at bits [i*CNT_W +: CNT_W].
- ph_clk  out  NUM_PH  divided, phase-shifted clocks (registered data, not used as clocks inside this block).
- ph_pulse  out  NUM_PH  one-cycle rise strobe per phase (optional feature).
- locked  out  1  outputs reflect the active configuration.

Behaviour:
- Reset values:
  - cnt=0.
  - active div = DEFAULT_DIV.
  - all active phases = i*(DEFAULT_DIV/NUM_PH).
  - shadow empty; cfg_ready=1.
  - ph_clk=0, ph_pulse=0, locked=0.
  - FSM = IDLE.
- FSM states IDLE, SYNC, RUN:
  - IDLE: cnt held at 0, ph_clk=0, locked=0. en=1 -> SYNC.
  - SYNC: cnt runs. When cnt==div-1 -> RUN and locked=1 on the next cycle.
  - RUN: cnt runs. A shadow config applied at wrap -> SYNC (locked drops the cycle after the wrap).
  - en=0 in any state -> IDLE on the next cycle.
- Counter: cnt counts 0..div-1, then wraps to 0.
- Phase output: ph_clk[i] = ((cnt - ph_i) mod div) < (div>>1).
  - Computed from the current cnt and registered, so latency is 1 cycle.
  - For odd div, the high time is floor(div/2).
- Arithmetic rules:
  - The mod uses a CNT_W+1-bit subtraction with a conditional add of div; no divider is inferred.
  - div_cfg < 2 is clamped to 2.
  - A phase_cfg field >= div_cfg is clamped to div_cfg-1.
  - Clamping happens at capture.
- Handshake:
  - Capture into the shadow registers on cfg_valid && cfg_ready.
  - cfg_ready falls the next cycle and stays low until the shadow is applied.
  - Apply in the cycle cnt==div-1 (the next cnt is 0, with the new values).
  - In IDLE the shadow applies immediately on the next cycle.
- Simultaneous events:
  - Capture and wrap in the same cycle: the new value is not applied until the next wrap.
  - en falling in the same cycle as an apply: the apply still completes.
- rst_n low mid-operation: all state returns to reset values immediately; any pending shadow is discarded.

Optional Feature:
- Macro: CLOCK_PHASE_GEN_PULSE_EN.
- With the macro defined: ph_pulse[i]=1 for exactly one cycle, coincident with each 0->1 transition of ph_clk[i]. It stays 0 while in IDLE.
- Without the macro: ph_pulse is tied to 0 and the edge-detect registers are not built.

Decomposition:
- Package clock_phase_gen_pkg holds:
  - the FSM state enum (IDLE/SYNC/RUN);
  - the clamp function for div and phase;
  - the MIN_DIV=2 constant.
- One sub-module, clock_phase_slice, instantiated NUM_PH times. Each slice does the modular compare, the ph_clk register and the optional edge-detect.

Test Plan:
- Reset and defaults: release rst_n, en=1, DEFAULT_DIV=8, NUM_PH=4 -> phases offset by 0/2/4/6 cycles, each 4 high / 4 low. locked rises 9 cycles after en.
- Reconfigure mid-run: div_cfg=6, phases 0/1/2/3 accepted at cnt=3 -> cfg_ready low until the wrap. Period becomes 6 from the wrap onward. locked low for 1 period, then high.
- Clamping: div_cfg=1 and phase 9 -> div=2, phase=1, giving alternating 1/0 outputs with phase1 inverted relative to phase0.
- Odd divide and simultaneous events: div_cfg=5 -> 2 high / 3 low. A capture in the same cycle as the wrap is applied at the following wrap.
- Disable and reset mid-operation: en=0 -> IDLE next cycle with outputs 0. rst_n pulsed low while a shadow is pending -> cfg_ready=1 and div back to 8.
- Optional feature: with CLOCK_PHASE_GEN_PULSE_EN defined, ph_pulse is a single-cycle pulse per rise. Without it, ph_pulse is constantly 0.
